uart_core_param: RTL and testbench
==================================

# uart_core_param

Parametrised full-duplex UART core with an integrated baud tick generator, a transmitter, a receiver and first-word-fall-through Tx/Rx FIFOs. It generalises the fixed 8N1 UART with loopback. Data width, parity mode, stop-bit count, oversampling ratio, baud divider and FIFO depth are configurable. It adds parity and framing error detection, receive-overrun detection, start-bit glitch rejection and a runtime loopback select. It sits between a host-side register/bus adapter and the serial pins.

## Interface
- DATA_BITS, 8: payload bits per frame, 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- OVERSAMPLE, 16: baud ticks per bit, even, ≥ 8.
- BAUD_DIV, 54: CLK cycles per baud tick, ≥ 2.
- FIFO_AW, 4: FIFO depth is 2^FIFO_AW words (both FIFOs).

- CLK  in  1  single clock, rising edge.
- Areset  in  1  asynchronous, active-high reset.
- tx_wr_en  in  1  push tx_wr_data into the Tx FIFO.
- tx_wr_data  in  DATA_BITS  word to transmit.
- tx_full  out  1  Tx FIFO full.
- tx_empty  out  1  Tx FIFO empty.
- tx_busy  out  1  transmitter not in IDLE.
- rx_rd_en  in  1  pop the Rx FIFO head.
- rx_rd_data  out  DATA_BITS  Rx FIFO head word (FWFT).
- rx_parity_err  out  1  parity error flag of the head word.
- rx_frame_err  out  1  framing error flag of the head word.
- rx_empty  out  1  Rx FIFO empty.
- rx_full  out  1  Rx FIFO full.
- rx_overrun  out  1  sticky: a received word was dropped.
- err_clr  in  1  clears rx_overrun.
- loopback  in  1  1 = the receiver takes the internal txd instead of rxd.
- rxd  in  1  serial input, asynchronous.
- txd  out  1  serial output, idle high.

## Operation
- **Tick generator:** a counter runs 0..BAUD_DIV-1; tick is asserted for one cycle when the count equals BAUD_DIV-1, then the counter wraps. It is free-running from reset.
- **Frame format:** start bit (0), then DATA_BITS bits LSB first, then an optional parity bit, then STOP_BITS stop bits (1).
  - Odd parity: data bits plus the parity bit have an odd count of ones.
  - Even parity: that count is even.
- **Tx FSM: IDLE → START → DATA → PARITY → STOP → IDLE.** PARITY is skipped when PARITY = 0.
  - In IDLE with Tx FIFO not empty: pop the head into the shift register and enter START.
  - Each bit holds for OVERSAMPLE ticks. A tick counter and a bit counter sequence DATA and STOP.
- **Rx front end:** the line (rxd, or internal txd when loopback = 1) passes through a 2-flop synchroniser.
- **Rx FSM: IDLE → START → DATA → PARITY → STOP → IDLE.**
  - IDLE → START on a synchronised 0.
  - In START, after OVERSAMPLE/2 ticks, sample the line. A 1 is a glitch: return to IDLE with no push.
  - Otherwise, sample each later bit after OVERSAMPLE ticks (mid-bit).
  - Only the first stop bit is checked. A 0 sets frame_err for this word.
  - Parity mismatch sets parity_err.
  - At the end of the first stop bit, push {frame_err, parity_err, data} and return to IDLE. The Rx FSM accepts a new start bit immediately, even if STOP_BITS = 2.
- **FIFOs:** circular buffers with an FWFT head.
  - Tx FIFO: DATA_BITS wide. Rx FIFO: DATA_BITS+2 wide (data plus the two error flags).
  - Writing a full FIFO is ignored, even if a read happens in the same cycle.
  - Reading an empty FIFO is ignored.
  - Simultaneous read and write on a non-empty, non-full FIFO: occupancy is unchanged.
  - An Rx push into a full FIFO drops the word and sets rx_overrun.
  - err_clr clears rx_overrun. If an overrun occurs in the same cycle as err_clr, rx_overrun stays set.
- **Loopback:** does not alter txd. It is sampled continuously; changing it mid-frame may corrupt the frame in progress.

## Timing
- **Reset values:**
  - txd = 1.
  - tx_empty = 1, rx_empty = 1.
  - tx_full, rx_full, tx_busy, rx_overrun, rx_parity_err, rx_frame_err = 0.
  - rx_rd_data = 0.
  - Both FSMs in IDLE, all counters 0, synchroniser flops = 1.
- Reset asserted mid-frame aborts both frames immediately and empties both FIFOs.
- **Tx latency:**
  - A write in cycle N to an empty FIFO with Tx idle: tx_empty deasserts at N+1; the pop happens at N+1; txd = 0 and tx_busy = 1 from N+2.
  - Back-to-back frames: the next pop occurs in the IDLE cycle right after the last stop bit, giving one extra idle-high cycle between frames.
- **Bit period:** OVERSAMPLE × BAUD_DIV cycles. The start bit may be shortened by up to BAUD_DIV-1 cycles because of tick phase.
- **Rx latency:** the word is visible on rx_rd_data, with rx_empty = 0, one cycle after the push.
- **Pop timing:** rx_rd_en pops at the clock edge; the next head is visible the following cycle.

## Test plan
- **8N1 loopback** (BAUD_DIV = 4, OVERSAMPLE = 16, loopback = 1): write 0xA5 → txd shows 0, 1,0,1,0,0,1,0,1, 1 at 64 cycles per bit. rx_rd_data = 0xA5 with both error flags 0 within 700 cycles.
- **Even parity** (PARITY = 2): send 0x07 → parity bit = 1. Drive rxd externally with a flipped parity bit → rx_parity_err = 1 and data = 0x07.
- **Framing error:** drive rxd with stop bit = 0 for 0x3C → rx_frame_err = 1, rx_rd_data = 0x3C.
- **Glitch rejection:** drive rxd low for 3 ticks only → no push, rx_empty stays 1.
- **FIFO limits** (FIFO_AW = 2):
  - Write 5 words while txd is busy → tx_full after 4 accepted, 5th dropped; exactly 4 frames are sent.
  - Receive 5 words without reading → rx_overrun = 1; err_clr clears it.
- **Reset mid-frame:** assert Areset during DATA → txd = 1, tx_empty = 1, rx_empty = 1 immediately; the next write transmits correctly.

Source files
------------

// File: rtl/uart_core_param.sv
// rtl/uart_core_param.sv - parametrised full-duplex UART core with baud tick, Tx/Rx FSMs and FWFT FIFOs

// Circular-buffer FIFO with a first-word-fall-through head; the head reads as 0 when empty.
module uart_core_param_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_wr, do_rd;

  // A full FIFO refuses writes even when a read frees a slot in the same cycle.
  assign do_wr     = wr_en_i & ~full_o;
  assign do_rd     = rd_en_i & ~empty_o;
  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == (AW+1)'(DEPTH));
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Occupancy next state: simultaneous read and write leave it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end
endmodule

module uart_core_param #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int BAUD_DIV   = 54,
  parameter int FIFO_AW    = 4
) (
  input  logic                 CLK,
  input  logic                 Areset,
  input  logic                 tx_wr_en,
  input  logic [DATA_BITS-1:0] tx_wr_data,
  output logic                 tx_full,
  output logic                 tx_empty,
  output logic                 tx_busy,
  input  logic                 rx_rd_en,
  output logic [DATA_BITS-1:0] rx_rd_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_empty,
  output logic                 rx_full,
  output logic                 rx_overrun,
  input  logic                 err_clr,
  input  logic                 loopback,
  input  logic                 rxd,
  output logic                 txd
);
  localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int RW = DATA_BITS + 2;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] OS_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    DB_LAST   = 4'(DATA_BITS - 1);
  localparam logic [3:0]    SB_LAST   = 4'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- baud tick ----------------
  logic [BW-1:0] baud_cnt_q, baud_cnt_d;
  logic          tick;

  assign tick       = (baud_cnt_q == BAUD_LAST);
  assign baud_cnt_d = tick ? '0 : baud_cnt_q + BW'(1);

  // Free-running tick divider shared by both directions.
  always_ff @(posedge CLK or posedge Areset) begin
    if (Areset) baud_cnt_q <= '0;
    else        baud_cnt_q <= baud_cnt_d;
  end

  // ---------------- transmitter ----------------
  state_t                tx_state_q;
  logic [DATA_BITS-1:0]  tx_shift_q;
  logic                  tx_par_q;
  logic [TW-1:0]         tx_tcnt_q;
  logic [3:0]            tx_bcnt_q;
  logic                  txd_q, tx_busy_q;
  logic [DATA_BITS-1:0]  tx_head;
  logic                  tx_fifo_empty, tx_pop;

  assign tx_pop = (tx_state_q == S_IDLE) && !tx_fifo_empty;

  uart_core_param_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_tx_fifo (
    .clk_i     (CLK),
    .rst_i     (Areset),
    .wr_en_i   (tx_wr_en),
    .wr_data_i (tx_wr_data),
    .rd_en_i   (tx_pop),
    .rd_data_o (tx_head),
    .empty_o   (tx_fifo_empty),
    .full_o    (tx_full)
  );

  // Tx FSM: each bit lasts OVERSAMPLE ticks; txd is updated as each bit begins.
  always_ff @(posedge CLK or posedge Areset) begin
    if (Areset) begin
      tx_state_q <= S_IDLE;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_tcnt_q  <= '0;
      tx_bcnt_q  <= '0;
      txd_q      <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      case (tx_state_q)
        S_IDLE: begin
          if (!tx_fifo_empty) begin
            tx_shift_q <= tx_head;
            tx_par_q   <= (^tx_head) ^ PAR_ODD;
            tx_tcnt_q  <= '0;
            tx_bcnt_q  <= '0;
            txd_q      <= 1'b0;
            tx_busy_q  <= 1'b1;
            tx_state_q <= S_START;
          end
        end
        default: begin
          if (tick) begin
            if (tx_tcnt_q != OS_LAST) begin
              tx_tcnt_q <= tx_tcnt_q + TW'(1);
            end else begin
              tx_tcnt_q <= '0;
              case (tx_state_q)
                S_START: begin
                  txd_q      <= tx_shift_q[0];
                  tx_shift_q <= tx_shift_q >> 1;
                  tx_state_q <= S_DATA;
                end
                S_DATA: begin
                  if (tx_bcnt_q == DB_LAST) begin
                    tx_bcnt_q <= '0;
                    if (PARITY != 0) begin
                      txd_q      <= tx_par_q;
                      tx_state_q <= S_PARITY;
                    end else begin
                      txd_q      <= 1'b1;
                      tx_state_q <= S_STOP;
                    end
                  end else begin
                    tx_bcnt_q  <= tx_bcnt_q + 4'd1;
                    txd_q      <= tx_shift_q[0];
                    tx_shift_q <= tx_shift_q >> 1;
                  end
                end
                S_PARITY: begin
                  txd_q      <= 1'b1;
                  tx_state_q <= S_STOP;
                end
                S_STOP: begin
                  if (tx_bcnt_q == SB_LAST) begin
                    tx_bcnt_q  <= '0;
                    tx_busy_q  <= 1'b0;
                    tx_state_q <= S_IDLE;
                  end else begin
                    tx_bcnt_q <= tx_bcnt_q + 4'd1;
                  end
                end
                default: tx_state_q <= S_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign txd      = txd_q;
  assign tx_busy  = tx_busy_q;
  assign tx_empty = tx_fifo_empty;

  // ---------------- receiver ----------------
  logic [1:0]           sync_q;
  logic                 rx_s;
  state_t               rx_state_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic [TW-1:0]        rx_tcnt_q;
  logic [3:0]           rx_bcnt_q;
  logic                 rx_perr_q;
  logic                 rx_push_q;
  logic [RW-1:0]        rx_word_q;
  logic [RW-1:0]        rx_head;
  logic                 rx_overrun_q, rx_overrun_d;

  assign rx_s = sync_q[1];

  // Two-flop synchroniser on the selected line; idles high.
  always_ff @(posedge CLK or posedge Areset) begin
    if (Areset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], loopback ? txd_q : rxd};
  end

  // Rx FSM: half-bit start qualification, then mid-bit sampling; word pushed once the first stop bit is sampled.
  always_ff @(posedge CLK or posedge Areset) begin
    if (Areset) begin
      rx_state_q <= S_IDLE;
      rx_shift_q <= '0;
      rx_tcnt_q  <= '0;
      rx_bcnt_q  <= '0;
      rx_perr_q  <= 1'b0;
      rx_push_q  <= 1'b0;
      rx_word_q  <= '0;
    end else begin
      rx_push_q <= 1'b0;
      case (rx_state_q)
        S_IDLE: begin
          if (!rx_s) begin
            rx_tcnt_q  <= '0;
            rx_bcnt_q  <= '0;
            rx_perr_q  <= 1'b0;
            rx_state_q <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            if (rx_tcnt_q != HALF_LAST) begin
              rx_tcnt_q <= rx_tcnt_q + TW'(1);
            end else begin
              rx_tcnt_q  <= '0;
              rx_state_q <= rx_s ? S_IDLE : S_DATA;
            end
          end
        end
        default: begin
          if (tick) begin
            if (rx_tcnt_q != OS_LAST) begin
              rx_tcnt_q <= rx_tcnt_q + TW'(1);
            end else begin
              rx_tcnt_q <= '0;
              case (rx_state_q)
                S_DATA: begin
                  rx_shift_q <= {rx_s, rx_shift_q[DATA_BITS-1:1]};
                  if (rx_bcnt_q == DB_LAST) begin
                    rx_bcnt_q  <= '0;
                    rx_state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                  end else begin
                    rx_bcnt_q <= rx_bcnt_q + 4'd1;
                  end
                end
                S_PARITY: begin
                  rx_perr_q  <= (^rx_shift_q) ^ rx_s ^ PAR_ODD;
                  rx_state_q <= S_STOP;
                end
                S_STOP: begin
                  rx_word_q  <= {~rx_s, rx_perr_q, rx_shift_q};
                  rx_push_q  <= 1'b1;
                  rx_state_q <= S_IDLE;
                end
                default: rx_state_q <= S_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  uart_core_param_fifo #(.W(RW), .AW(FIFO_AW)) u_rx_fifo (
    .clk_i     (CLK),
    .rst_i     (Areset),
    .wr_en_i   (rx_push_q),
    .wr_data_i (rx_word_q),
    .rd_en_i   (rx_rd_en),
    .rd_data_o (rx_head),
    .empty_o   (rx_empty),
    .full_o    (rx_full)
  );

  // A new overrun wins over a simultaneous clear.
  assign rx_overrun_d = (rx_overrun_q & ~err_clr) | (rx_push_q & rx_full);

  // Sticky overrun flag.
  always_ff @(posedge CLK or posedge Areset) begin
    if (Areset) rx_overrun_q <= 1'b0;
    else        rx_overrun_q <= rx_overrun_d;
  end

  assign rx_overrun    = rx_overrun_q;
  assign rx_rd_data    = rx_head[DATA_BITS-1:0];
  assign rx_parity_err = rx_head[DATA_BITS];
  assign rx_frame_err  = rx_head[DATA_BITS+1];
endmodule

// File: tb/tb_uart_core_param.sv
// tb/tb_uart_core_param.sv - scoreboard bench for uart_core_param (8E1, 64 cycles per bit, 4-deep FIFOs)
module tb_uart_core_param;
  localparam int BIT = 64;

  logic       CLK, Areset;
  logic       tx_wr_en;
  logic [7:0] tx_wr_data;
  logic       tx_full, tx_empty, tx_busy;
  logic       rx_rd_en;
  logic [7:0] rx_rd_data;
  logic       rx_parity_err, rx_frame_err, rx_empty, rx_full, rx_overrun;
  logic       err_clr, loopback, rxd, txd;

  int n_vec = 0;
  int n_err = 0;
  int n_rx  = 0;
  logic auto_read;
  logic [9:0] sb[$];

  uart_core_param #(
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
    .OVERSAMPLE(16), .BAUD_DIV(4), .FIFO_AW(2)
  ) dut (
    .CLK(CLK), .Areset(Areset),
    .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data),
    .tx_full(tx_full), .tx_empty(tx_empty), .tx_busy(tx_busy),
    .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .rx_empty(rx_empty), .rx_full(rx_full), .rx_overrun(rx_overrun),
    .err_clr(err_clr), .loopback(loopback), .rxd(rxd), .txd(txd)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Rx monitor: pops every head word while auto_read is set and compares with the scoreboard.
  initial begin
    rx_rd_en = 1'b0;
    forever begin
      @(negedge CLK);
      rx_rd_en = 1'b0;
      if (auto_read && !Areset && !rx_empty) begin
        if (sb.size() == 0) begin
          check("rx_spurious", sb.size(), 1);
        end else begin
          check("rx_word", {rx_frame_err, rx_parity_err, rx_rd_data}, sb.pop_front());
        end
        n_rx++;
        rx_rd_en = 1'b1;
      end
    end
  end

  task automatic send_tx(input logic [7:0] d, input logic expect_rx);
    @(negedge CLK);
    tx_wr_en   = 1'b1;
    tx_wr_data = d;
    if (expect_rx) sb.push_back({2'b00, d});
    @(negedge CLK);
    tx_wr_en = 1'b0;
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 200 && !tx_busy; i++) @(negedge CLK);
    check("tx_busy_wait", tx_busy, 1);
  endtask

  task automatic check_txd_frame(input logic [7:0] d);
    logic [10:0] fr;
    fr = {1'b1, ^d, d, 1'b0};
    for (int i = 0; i < 2000 && txd; i++) @(negedge CLK);
    check("txd_start", txd, 0);
    repeat (BIT/2 - 1) @(negedge CLK);
    for (int i = 0; i < 11; i++) begin
      check("txd_bit", txd, fr[i]);
      repeat (BIT) @(negedge CLK);
    end
  endtask

  task automatic drive_rx(input logic [7:0] d, input logic flip, input logic stop);
    loopback = 1'b0;
    sb.push_back({~stop, flip, d});
    @(negedge CLK);
    rxd = 1'b0;
    repeat (BIT) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (BIT) @(negedge CLK);
    end
    rxd = (^d) ^ flip;
    repeat (BIT) @(negedge CLK);
    rxd = stop;
    repeat (stop ? BIT : 48) @(negedge CLK);
    rxd = 1'b1;
    repeat (BIT) @(negedge CLK);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge CLK);
    check("scoreboard_drain", sb.size(), 0);
    repeat (200) @(negedge CLK);
  endtask

  initial begin
    int base;
    Areset = 1'b1; tx_wr_en = 1'b0; tx_wr_data = '0;
    err_clr = 1'b0; loopback = 1'b1; rxd = 1'b1; auto_read = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_txd", txd, 1);
    check("rst_tx_empty", tx_empty, 1);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_tx_full", tx_full, 0);
    check("rst_rx_full", rx_full, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_overrun", rx_overrun, 0);
    check("rst_flags", {rx_frame_err, rx_parity_err}, 0);
    check("rst_rd_data", rx_rd_data, 0);
    Areset = 1'b0;
    repeat (5) @(negedge CLK);

    // Loopback 0xA5 with write-to-start latency.
    send_tx(8'hA5, 1'b1);
    check("lat_tx_empty", tx_empty, 0);
    check("lat_txd_idle", txd, 1);
    @(negedge CLK);
    check("lat_txd_start", txd, 0);
    check("lat_busy", tx_busy, 1);
    check_txd_frame(8'hA5);
    wait_drain(1500);

    // Even parity on the wire, then an external frame with a flipped parity bit.
    send_tx(8'h07, 1'b1);
    check_txd_frame(8'h07);
    wait_drain(1500);
    drive_rx(8'h07, 1'b1, 1'b1);
    wait_drain(1500);

    // Framing error.
    drive_rx(8'h3C, 1'b0, 1'b0);
    wait_drain(1500);

    // Start-bit glitch of 3 ticks, then a clean frame.
    @(negedge CLK);
    rxd = 1'b0;
    repeat (12) @(negedge CLK);
    rxd = 1'b1;
    repeat (300) @(negedge CLK);
    check("glitch_rx_empty", rx_empty, 1);
    drive_rx(8'h96, 1'b0, 1'b1);
    wait_drain(1500);

    // Tx FIFO limit: one frame in flight, four queued, fifth dropped.
    loopback = 1'b1;
    base = n_rx;
    send_tx(8'h11, 1'b1);
    wait_busy();
    send_tx(8'h22, 1'b1);
    send_tx(8'h33, 1'b1);
    send_tx(8'h44, 1'b1);
    send_tx(8'h55, 1'b1);
    check("tx_full", tx_full, 1);
    send_tx(8'h66, 1'b0);
    check("tx_full_hold", tx_full, 1);
    wait_drain(6000);
    check("frames_sent", n_rx - base, 5);
    check("tx_empty_after", tx_empty, 1);

    // Rx overrun with reads stalled; fifth word is dropped.
    auto_read = 1'b0;
    send_tx(8'h01, 1'b1);
    wait_busy();
    send_tx(8'h02, 1'b1);
    send_tx(8'h03, 1'b1);
    send_tx(8'h04, 1'b1);
    send_tx(8'h05, 1'b0);
    for (int i = 0; i < 6000 && !(tx_empty && !tx_busy); i++) @(negedge CLK);
    check("tx_idle_wait", {tx_empty, tx_busy}, 2'b10);
    repeat (100) @(negedge CLK);
    check("rx_full", rx_full, 1);
    check("rx_overrun_set", rx_overrun, 1);
    err_clr = 1'b1;
    @(negedge CLK);
    err_clr = 1'b0;
    check("rx_overrun_clr", rx_overrun, 0);
    auto_read = 1'b1;
    wait_drain(100);
    check("rx_empty_drained", rx_empty, 1);

    // Reset in the middle of a data bit.
    send_tx(8'h33, 1'b0);
    wait_busy();
    repeat (300) @(negedge CLK);
    Areset = 1'b1;
    #1;
    check("midrst_txd", txd, 1);
    check("midrst_tx_empty", tx_empty, 1);
    check("midrst_rx_empty", rx_empty, 1);
    check("midrst_busy", tx_busy, 0);
    @(negedge CLK);
    Areset = 1'b0;
    repeat (5) @(negedge CLK);
    send_tx(8'h5A, 1'b1);
    check_txd_frame(8'h5A);
    wait_drain(1500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
